// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the memory responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} resp_state_t;
  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_WRITE = 1'b1;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_MEM = 1'b1;
  typedef struct packed {
    logic mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
  } mreq_t;
endpackage

// File: rtl/bram_bytewe.sv
// bram_bytewe: single-port byte-writable block RAM with registered read
module bram_bytewe #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  // read-first access: per-lane write and registered read of the old word
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: two-port request buffers, round-robin arbiter and BRAM responder
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        protocol_error
);
  resp_state_t state;
  logic [1:0] req, pending, resp_en;
  logic grant, last_grant;
  mreq_t incoming [2];
  mreq_t buffer [2];
  mreq_t cur;
  logic [31:0] dout, rdata, fhold, mhold;
  logic unused_addr;
  assign req = {mem_request_enable, fetch_request_enable};
  assign incoming[0] = {freq_mode, freq_addr, freq_wdata, freq_wstrb};
  assign incoming[1] = {mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb};
  assign cur = buffer[grant];
  assign unused_addr = ^{cur.addr[31:ADDR_WIDTH+2], cur.addr[1:0]};
  assign rdata = cur.mode == MODE_WRITE ? 32'h0 : dout;
  assign fetch_response_enable = resp_en[PORT_FETCH];
  assign mem_response_enable = resp_en[PORT_MEM];
  assign fresp_data = resp_en[PORT_FETCH] ? rdata : fhold;
  assign mresp_data = resp_en[PORT_MEM] ? rdata : mhold;
  bram_bytewe #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
    .clk  (clk),
    .en   (state == ACCESS),
    .we   (state == ACCESS && cur.mode == MODE_WRITE && !rst ? cur.wstrb : 4'h0),
    .addr (cur.addr[ADDR_WIDTH+1:2]),
    .wdata(cur.wdata),
    .rdata(dout)
  );
  // capture a request when the port is free or its response is going out this cycle
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (!rst && req[p] && (!pending[p] || resp_en[p])) buffer[p] <= incoming[p];
  end
  // pending flags, sticky error, held response data and the arbitration FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= 2'b00;
      grant <= PORT_FETCH;
      last_grant <= PORT_MEM;
      resp_en <= 2'b00;
      fhold <= 32'h0;
      mhold <= 32'h0;
      protocol_error <= 1'b0;
    end else begin
      pending <= (pending & ~resp_en) | req;
      if (|(req & pending & ~resp_en)) protocol_error <= 1'b1;
      if (resp_en[PORT_FETCH]) fhold <= fresp_data;
      if (resp_en[PORT_MEM]) mhold <= mresp_data;
      case (state)
        IDLE: if (|pending) begin
          grant <= &pending ? ~last_grant : pending[PORT_MEM];
          if (&pending) last_grant <= ~last_grant;
          state <= ACCESS;
        end
        ACCESS: begin
          resp_en[grant] <= 1'b1;
          state <= RESPOND;
        end
        RESPOND: begin
          resp_en <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks against a transaction-level model
module tb_mem_responder;
  import mem_resp_pkg::*;
  localparam int AW = 14;
  logic clk = 1'b0;
  logic rst;
  logic fetch_request_enable, freq_mode, mem_request_enable, mreq_mode;
  logic [31:0] freq_addr, freq_wdata, mreq_addr, mreq_wdata;
  logic [3:0] freq_wstrb, mreq_wstrb;
  logic fetch_response_enable, mem_response_enable, protocol_error;
  logic [31:0] fresp_data, mresp_data;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  int fq_c[$], mq_c[$];
  logic [31:0] fq_d[$], mq_d[$];
  logic [31:0] ref_mem [int];
  bit tie_fetch = 1'b1;

  mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .fetch_request_enable(fetch_request_enable), .freq_mode(freq_mode), .freq_addr(freq_addr),
    .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
    .fetch_response_enable(fetch_response_enable), .fresp_data(fresp_data),
    .mem_request_enable(mem_request_enable), .mreq_mode(mreq_mode), .mreq_addr(mreq_addr),
    .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mem_response_enable(mem_response_enable), .mresp_data(mresp_data),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // record every response pulse with the cycle it appeared in
  always @(negedge clk) begin
    if (fetch_response_enable === 1'b1) begin
      fq_c.push_back(cyc);
      fq_d.push_back(fresp_data);
    end
    if (mem_response_enable === 1'b1) begin
      mq_c.push_back(cyc);
      mq_d.push_back(mresp_data);
    end
  end

  function automatic int qi(int q[$], int i);
    return i < q.size() ? q[i] : -1;
  endfunction

  function automatic logic [31:0] qd(logic [31:0] q[$], int i);
    return i < q.size() ? q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % (32'd1 << AW));
  endfunction

  function automatic logic [31:0] model(bit mode, logic [31:0] a, logic [31:0] wd, logic [3:0] ws);
    int i = widx(a);
    logic [31:0] w = ref_mem.exists(i) ? ref_mem[i] : 32'h0;
    if (!mode) return w;
    for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
    ref_mem[i] = w;
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    fetch_request_enable = 1'b0;
    mem_request_enable = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clearq();
    fq_c.delete(); fq_d.delete(); mq_c.delete(); mq_d.delete();
  endtask

  task automatic send(input bit port, input bit mode, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (port == PORT_FETCH) begin
      fetch_request_enable = 1'b1; freq_mode = mode; freq_addr = a; freq_wdata = wd; freq_wstrb = ws;
    end else begin
      mem_request_enable = 1'b1; mreq_mode = mode; mreq_addr = a; mreq_wdata = wd; mreq_wstrb = ws;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_request_enable = 0; freq_mode = 0; freq_addr = 0; freq_wdata = 0; freq_wstrb = 0;
    mem_request_enable = 0; mreq_mode = 0; mreq_addr = 0; mreq_wdata = 0; mreq_wstrb = 0;
    run(2);
    total++; if (fetch_response_enable !== 1'b0) $display("FAIL reset_fresp_en got %b want 0", fetch_response_enable); else passed++;
    total++; if (mem_response_enable !== 1'b0) $display("FAIL reset_mresp_en got %b want 0", mem_response_enable); else passed++;
    total++; if (fresp_data !== 32'h0) $display("FAIL reset_fresp_data got %h want 0", fresp_data); else passed++;
    total++; if (mresp_data !== 32'h0) $display("FAIL reset_mresp_data got %h want 0", mresp_data); else passed++;
    total++; if (protocol_error !== 1'b0) $display("FAIL reset_perr got %b want 0", protocol_error); else passed++;
    rst = 1'b0;
    tie_fetch = 1'b1;
  endtask

  task automatic test_write_alias();
    int t0;
    clearq();
    send(PORT_MEM, MODE_WRITE, 32'h0000_0010, 32'hDEADBEEF, 4'hF);
    void'(model(MODE_WRITE, 32'h0000_0010, 32'hDEADBEEF, 4'hF));
    t0 = cyc;
    run(7);
    total++; if (mq_c.size() != 1 || qi(mq_c, 0) != t0 + 3) $display("FAIL wr_cycle got n=%0d c=%0d want n=1 c=%0d", mq_c.size(), qi(mq_c, 0), t0 + 3); else passed++;
    total++; if (qd(mq_d, 0) !== 32'h0) $display("FAIL wr_data got %h want 0", qd(mq_d, 0)); else passed++;
    total++; if (fq_c.size() != 0) $display("FAIL wr_fetch_quiet got %0d pulses want 0", fq_c.size()); else passed++;
    clearq();
    send(PORT_MEM, MODE_READ, 32'h0001_0010, 32'h0, 4'h0);
    t0 = cyc;
    run(7);
    total++; if (mq_c.size() != 1 || qi(mq_c, 0) != t0 + 3) $display("FAIL alias_cycle got n=%0d c=%0d want n=1 c=%0d", mq_c.size(), qi(mq_c, 0), t0 + 3); else passed++;
    total++; if (qd(mq_d, 0) !== 32'hDEADBEEF) $display("FAIL alias_data got %h want deadbeef", qd(mq_d, 0)); else passed++;
  endtask

  task automatic test_partial_write();
    int t0;
    clearq();
    send(PORT_MEM, MODE_WRITE, 32'h0000_0010, 32'h11223344, 4'b0101);
    void'(model(MODE_WRITE, 32'h0000_0010, 32'h11223344, 4'b0101));
    run(7);
    clearq();
    send(PORT_FETCH, MODE_READ, 32'h0000_0013, 32'hFFFF_FFFF, 4'hF);
    t0 = cyc;
    run(7);
    total++; if (fq_c.size() != 1 || qi(fq_c, 0) != t0 + 3) $display("FAIL partial_cycle got n=%0d c=%0d want n=1 c=%0d", fq_c.size(), qi(fq_c, 0), t0 + 3); else passed++;
    total++; if (qd(fq_d, 0) !== 32'hDE22BE44) $display("FAIL partial_data got %h want de22be44", qd(fq_d, 0)); else passed++;
  endtask

  task automatic test_round_robin();
    int t0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clearq();
    send(PORT_FETCH, MODE_READ, 32'h10, 32'h0, 4'h0);
    send(PORT_MEM, MODE_READ, 32'h10, 32'h0, 4'h0);
    t0 = cyc;
    run(9);
    total++; if (fq_c.size() != 1 || qi(fq_c, 0) != t0 + 3) $display("FAIL rr1_fetch got n=%0d c=%0d want n=1 c=%0d", fq_c.size(), qi(fq_c, 0), t0 + 3); else passed++;
    total++; if (mq_c.size() != 1 || qi(mq_c, 0) != t0 + 6) $display("FAIL rr1_mem got n=%0d c=%0d want n=1 c=%0d", mq_c.size(), qi(mq_c, 0), t0 + 6); else passed++;
    total++; if (qd(fq_d, 0) !== 32'hDE22BE44 || qd(mq_d, 0) !== 32'hDE22BE44) $display("FAIL rr1_data got %h/%h want de22be44", qd(fq_d, 0), qd(mq_d, 0)); else passed++;
    clearq();
    send(PORT_FETCH, MODE_READ, 32'h10, 32'h0, 4'h0);
    send(PORT_MEM, MODE_READ, 32'h10, 32'h0, 4'h0);
    t0 = cyc;
    run(9);
    total++; if (mq_c.size() != 1 || qi(mq_c, 0) != t0 + 3) $display("FAIL rr2_mem got n=%0d c=%0d want n=1 c=%0d", mq_c.size(), qi(mq_c, 0), t0 + 3); else passed++;
    total++; if (fq_c.size() != 1 || qi(fq_c, 0) != t0 + 6) $display("FAIL rr2_fetch got n=%0d c=%0d want n=1 c=%0d", fq_c.size(), qi(fq_c, 0), t0 + 6); else passed++;
    tie_fetch = 1'b1;
  endtask

  task automatic test_same_cycle();
    int t0;
    clearq();
    send(PORT_FETCH, MODE_READ, 32'h10, 32'h0, 4'h0);
    t0 = cyc;
    run(3);
    total++; if (fetch_response_enable !== 1'b1) $display("FAIL same_pulse got %b want 1", fetch_response_enable); else passed++;
    send(PORT_FETCH, MODE_READ, 32'h0002_0010, 32'h0, 4'h0);
    run(6);
    total++; if (fq_c.size() != 2 || qi(fq_c, 0) != t0 + 3 || qi(fq_c, 1) != t0 + 6) $display("FAIL same_cycles got n=%0d c=%0d,%0d want 2 at %0d,%0d", fq_c.size(), qi(fq_c, 0), qi(fq_c, 1), t0 + 3, t0 + 6); else passed++;
    total++; if (qd(fq_d, 1) !== 32'hDE22BE44) $display("FAIL same_data got %h want de22be44", qd(fq_d, 1)); else passed++;
    total++; if (protocol_error !== 1'b0) $display("FAIL same_perr got %b want 0", protocol_error); else passed++;
  endtask

  task automatic test_illegal();
    int t0;
    clearq();
    send(PORT_MEM, MODE_READ, 32'h10, 32'h0, 4'h0);
    t0 = cyc;
    tick();
    send(PORT_MEM, MODE_WRITE, 32'h10, 32'h0, 4'hF);
    tick();
    total++; if (protocol_error !== 1'b1) $display("FAIL illegal_perr got %b want 1", protocol_error); else passed++;
    run(6);
    total++; if (mq_c.size() != 1 || qi(mq_c, 0) != t0 + 3) $display("FAIL illegal_pulses got n=%0d c=%0d want n=1 c=%0d", mq_c.size(), qi(mq_c, 0), t0 + 3); else passed++;
    total++; if (qd(mq_d, 0) !== 32'hDE22BE44) $display("FAIL illegal_data got %h want de22be44", qd(mq_d, 0)); else passed++;
    clearq();
    send(PORT_FETCH, MODE_READ, 32'h10, 32'h0, 4'h0);
    run(7);
    total++; if (qd(fq_d, 0) !== 32'hDE22BE44) $display("FAIL illegal_dropped got %h want de22be44", qd(fq_d, 0)); else passed++;
    total++; if (protocol_error !== 1'b1) $display("FAIL illegal_sticky got %b want 1", protocol_error); else passed++;
  endtask

  task automatic test_reset_during_write();
    clearq();
    send(PORT_MEM, MODE_WRITE, 32'h20, 32'h0, 4'hF);
    void'(model(MODE_WRITE, 32'h20, 32'h0, 4'hF));
    run(7);
    clearq();
    send(PORT_MEM, MODE_WRITE, 32'h20, 32'hCAFEF00D, 4'hF);
    run(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tie_fetch = 1'b1;
    total++; if ({fetch_response_enable, mem_response_enable, protocol_error} !== 3'b000) $display("FAIL rstw_flags got %b want 000", {fetch_response_enable, mem_response_enable, protocol_error}); else passed++;
    total++; if ({fresp_data, mresp_data} !== 64'h0) $display("FAIL rstw_data got %h/%h want 0", fresp_data, mresp_data); else passed++;
    run(5);
    total++; if (mq_c.size() + fq_c.size() != 0) $display("FAIL rstw_nopulse got %0d pulses want 0", mq_c.size() + fq_c.size()); else passed++;
    send(PORT_FETCH, MODE_READ, 32'h20, 32'h0, 4'h0);
    run(7);
    total++; if (fq_c.size() != 1 || qd(fq_d, 0) !== 32'h0) $display("FAIL rstw_read got n=%0d d=%h want n=1 d=0", fq_c.size(), qd(fq_d, 0)); else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int kind = int'($urandom_range(0, 2));
      bit md [2];
      logic [31:0] ad [2], wd [2];
      logic [3:0] ws [2];
      int ec [2];
      logic [31:0] ed [2];
      int t0;
      bit first;
      for (int p = 0; p < 2; p++) begin
        ad[p] = ($urandom & 32'hFFFF_0000) | (32'h100 + 32'(4 * $urandom_range(0, 7))) | 32'($urandom_range(0, 3));
        md[p] = 1'($urandom_range(0, 1));
        wd[p] = $urandom;
        ws[p] = 4'($urandom);
        if (!ref_mem.exists(widx(ad[p]))) begin md[p] = 1'b1; ws[p] = 4'hF; end
        ec[p] = -1;
        ed[p] = 32'h0;
      end
      clearq();
      t0 = cyc;
      if (kind == 2) begin
        first = tie_fetch ? PORT_FETCH : PORT_MEM;
        tie_fetch = !tie_fetch;
        send(PORT_FETCH, md[0], ad[0], wd[0], ws[0]);
        send(PORT_MEM, md[1], ad[1], wd[1], ws[1]);
        ec[first] = t0 + 3;
        ed[first] = model(md[first], ad[first], wd[first], ws[first]);
        ec[!first] = t0 + 6;
        ed[!first] = model(md[!first], ad[!first], wd[!first], ws[!first]);
      end else begin
        send(1'(kind), md[kind], ad[kind], wd[kind], ws[kind]);
        ec[kind] = t0 + 3;
        ed[kind] = model(md[kind], ad[kind], wd[kind], ws[kind]);
      end
      run(9);
      total++; if (fq_c.size() != (ec[0] >= 0 ? 1 : 0) || (ec[0] >= 0 && qi(fq_c, 0) != ec[0])) $display("FAIL rnd%0d_fetch_cycle got n=%0d c=%0d want c=%0d", it, fq_c.size(), qi(fq_c, 0), ec[0]); else passed++;
      total++; if (mq_c.size() != (ec[1] >= 0 ? 1 : 0) || (ec[1] >= 0 && qi(mq_c, 0) != ec[1])) $display("FAIL rnd%0d_mem_cycle got n=%0d c=%0d want c=%0d", it, mq_c.size(), qi(mq_c, 0), ec[1]); else passed++;
      if (ec[0] >= 0) begin
        total++; if (qd(fq_d, 0) !== ed[0]) $display("FAIL rnd%0d_fetch_data got %h want %h", it, qd(fq_d, 0), ed[0]); else passed++;
      end
      if (ec[1] >= 0) begin
        total++; if (qd(mq_d, 0) !== ed[1]) $display("FAIL rnd%0d_mem_data got %h want %h", it, qd(mq_d, 0), ed[1]); else passed++;
      end
    end
    total++; if (protocol_error !== 1'b0) $display("FAIL rnd_perr got %b want 0", protocol_error); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_alias();
    test_partial_write();
    test_round_robin();
    test_same_cycle();
    test_illegal();
    test_reset_during_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
